// File: rtl/regbank_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regbank_write_arbiter_if
//
// Purpose: bundles the requester handshake (req/lock/addr/data/ack) and the
// register-bank write port (wr_en/wr_addr/wr_data/owner) of the register bank
// write arbiter.
//
// Parameters:
//   NREQ - number of requesters
//   DW   - register data width
//
// Signals:
//   req     [NREQ]      write request per requester, held until ack
//   lock    [NREQ]      burst request per requester, sampled with req
//   addr    [NREQ*4]    register index, requester i at [4i+3:4i]
//   data    [NREQ*DW]   write data, requester i at [DW*i+DW-1:DW*i]
//   ack     [NREQ]      one-hot accept, combinational
//   wr_en               registered write strobe
//   wr_addr [4]         registered register index
//   wr_data [DW]        registered write data
//   owner   [clog2]     registered index of the last granted requester
//
// Modports:
//   master - requester side (drives the request bundle)
//   slave  - arbiter side (drives ack and the write port)
// ---------------------------------------------------------------------------
interface regbank_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*4-1:0]  addr;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    ack;
    logic               wr_en;
    logic [3:0]         wr_addr;
    logic [DW-1:0]      wr_data;
    logic [OW-1:0]      owner;

    modport master (
        output req, lock, addr, data,
        input  ack, wr_en, wr_addr, wr_data, owner
    );

    modport slave (
        input  req, lock, addr, data,
        output ack, wr_en, wr_addr, wr_data, owner
    );
endinterface

// File: rtl/regbank_write_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_write_arbiter
//
// Purpose: shares the single write port of the 16-entry register bank among
// NREQ requesters. Round-robin arbitration with an optional bounded burst
// lock: a requester granted with lock=1 keeps the port for up to MAX_BURST
// consecutive writes. Accepted writes appear on the registered write port one
// cycle after the combinational ack.
//
// Parameters:
//   NREQ      - number of requesters (2..8)
//   DW        - register data width
//   MAX_BURST - max consecutive writes per locked grant (1 disables bursts)
//
// Ports:
//   clk - clock, rising edge
//   rst - synchronous reset, active high
//   bus - regbank_write_arbiter_if.slave (request bundle in, ack and write
//         port out)
//
// Optional feature macro: REGBANK_R0_PROTECT_EN
//   When defined, a granted write to register 0 is acked and advances the
//   arbitration state, but wr_en stays low so register 0 is never written.
// ---------------------------------------------------------------------------
module regbank_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    regbank_write_arbiter_if.slave  bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [3:0]      wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [OW-1:0]   owner_q, owner_d;

    logic [3:0]      addr_a [NREQ];
    logic [DW-1:0]   data_a [NREQ];
    logic            win_found_s;
    logic [OW-1:0]   win_s;
    logic [OW-1:0]   sel_s;
    logic            grant_s;
    logic            wr_allow_s;
    logic [NREQ-1:0] ack_s;

    // Unpack the flat request payload buses into per-requester arrays.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i] = bus.addr[4*i +: 4];
            data_a[i] = bus.data[DW*i +: DW];
        end
    end

    // Round-robin search: first set req bit at or above rr, wrapping to 0.
    always_comb begin
        int            cand;
        logic [OW-1:0] cand_idx;
        win_found_s = 1'b0;
        win_s       = {OW{1'b0}};
        cand        = 0;
        cand_idx    = {OW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand     = (int'(rr_q) + k >= NREQ) ? (int'(rr_q) + k - NREQ) : (int'(rr_q) + k);
            cand_idx = OW'(cand);
            if (!win_found_s && bus.req[cand_idx]) begin
                win_found_s = 1'b1;
                win_s       = cand_idx;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // During a burst only the current owner may be granted.
    assign sel_s   = (state_q == BURST) ? owner_q : win_s;
    assign grant_s = (state_q == BURST) ? bus.req[owner_q] : win_found_s;

`ifdef REGBANK_R0_PROTECT_EN
    // Register 0 is read-only: accept the write but suppress the strobe.
    assign wr_allow_s = (addr_a[sel_s] != 4'd0);
`else
    assign wr_allow_s = 1'b1;
`endif

    // ack is combinational and suppressed while reset is held.
    assign ack_s = (grant_s && !rst) ? (NREQ'(1'b1) << sel_s) : {NREQ{1'b0}};

    // Next-state logic for arbitration state, burst counter and write port.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        owner_d   = owner_q;

        if (grant_s) begin
            wr_en_d   = wr_allow_s;
            wr_addr_d = addr_a[sel_s];
            wr_data_d = data_a[sel_s];
            owner_d   = sel_s;
        end else begin
            wr_en_d   = 1'b0;
        end

        case (state_q)
            ARB: begin
                if (grant_s) begin
                    rr_d = (win_s == OW'(NREQ - 1)) ? {OW{1'b0}} : (win_s + OW'(1));
                    if (bus.lock[win_s] && (MAX_BURST > 1)) begin
                        state_d = BURST;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = ARB;
                    end
                end else begin
                    state_d = ARB;
                end
            end
            BURST: begin
                // rr is left at owner+1 for the whole burst.
                if (grant_s) begin
                    cnt_d = cnt_q + CW'(1);
                    if (!bus.lock[owner_q] || ((cnt_q + CW'(1)) == CW'(MAX_BURST))) begin
                        state_d = ARB;
                    end else begin
                        state_d = BURST;
                    end
                end else begin
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // State and output registers; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            rr_q      <= {OW{1'b0}};
            cnt_q     <= CW'(1);
            wr_en_q   <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= {DW{1'b0}};
            owner_q   <= {OW{1'b0}};
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            owner_q   <= owner_d;
        end
    end

    assign bus.ack     = ack_s;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.owner   = owner_q;

endmodule
